// File: rtl/gray_enc_arbiter_if.sv
// Client-side bundle of the shared Gray encoder arbiter:
// request/operand lanes, ack/result returns and encoder hookup.
interface gray_enc_arbiter_if #(
  parameter int REQ_NUM = 4,
  parameter int DW      = 4,
  parameter int IDW     = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
);
  logic [REQ_NUM-1:0]    i_req;
  logic [REQ_NUM*DW-1:0] i_data;
  logic [REQ_NUM-1:0]    o_ack;
  logic [DW-1:0]         o_gray;
  logic [IDW-1:0]        o_gnt_id;
  logic                  o_busy;
  logic [DW-1:0]         o_enc_data;
  logic [DW-1:0]         i_enc_gray;

  modport master (
    output i_req,
    output i_data,
    output i_enc_gray,
    input  o_ack,
    input  o_gray,
    input  o_gnt_id,
    input  o_busy,
    input  o_enc_data
  );

  modport slave (
    input  i_req,
    input  i_data,
    input  i_enc_gray,
    output o_ack,
    output o_gray,
    output o_gnt_id,
    output o_busy,
    output o_enc_data
  );
endinterface

// File: rtl/gray_enc_arbiter.sv
// Round-robin share of one registered binary-to-Gray encoder
// among REQ_NUM requesters; result returned with a one-hot ack.
module gray_enc_arbiter_core #(
  parameter int REQ_NUM = 4,
  parameter int DW      = 4,
  parameter int ENC_LAT = 1
) (
  input logic        i_clk,
  input logic        i_rst_n,
  gray_enc_arbiter_if.slave bus
);
  localparam int IDW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int CW  = $clog2(ENC_LAT + 1);
  localparam logic [REQ_NUM-1:0] ONE =
    {{(REQ_NUM-1){1'b0}}, 1'b1};
  localparam logic [IDW-1:0] PTR_RST = IDW'(REQ_NUM - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     gnt_q, gnt_d;
  logic [DW-1:0]      enc_q, enc_d;
  logic [DW-1:0]      gray_q, gray_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [REQ_NUM-1:0] ack_q, ack_d;

  logic               hit;
  logic [IDW-1:0]     pick;
  logic [IDW-1:0]     idx;
  logic [DW-1:0]      lane [REQ_NUM];

  for (genvar k = 0; k < REQ_NUM; k++) begin : g_lane
    assign lane[k] = bus.i_data[k*DW +: DW];
  end

  // first set request strictly after the pointer, wrapping
  always_comb begin
    hit  = 1'b0;
    pick = ptr_q;
    idx  = ptr_q;
    for (int k = 1; k <= REQ_NUM; k++) begin
      idx = IDW'((int'(ptr_q) + k) % REQ_NUM);
      if (!hit && bus.i_req[idx]) begin
        hit  = 1'b1;
        pick = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    enc_d   = enc_q;
    gray_d  = gray_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          ptr_d   = pick;
          gnt_d   = pick;
          enc_d   = lane[pick];
          cnt_d   = CW'(ENC_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          gray_d  = bus.i_enc_gray;
          ack_d   = ONE << gnt_q;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= PTR_RST;
      gnt_q   <= '0;
      enc_q   <= '0;
      gray_q  <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      enc_q   <= enc_d;
      gray_q  <= gray_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.o_ack      = ack_q;
  assign bus.o_gray     = gray_q;
  assign bus.o_gnt_id   = gnt_q;
  assign bus.o_busy     = (state_q != IDLE);
  assign bus.o_enc_data = enc_q;
endmodule

module gray_enc_arbiter #(
  parameter int REQ_NUM = 4,
  parameter int DW      = 4,
  parameter int ENC_LAT = 1,
  localparam int IDW    = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [REQ_NUM-1:0]    i_req,
  input  logic [REQ_NUM*DW-1:0] i_data,
  output logic [REQ_NUM-1:0]    o_ack,
  output logic [DW-1:0]         o_gray,
  output logic [IDW-1:0]        o_gnt_id,
  output logic                  o_busy,
  output logic [DW-1:0]         o_enc_data,
  input  logic [DW-1:0]         i_enc_gray
);
  gray_enc_arbiter_if #(
    .REQ_NUM(REQ_NUM),
    .DW     (DW),
    .IDW    (IDW)
  ) bus ();

  assign bus.i_req      = i_req;
  assign bus.i_data     = i_data;
  assign bus.i_enc_gray = i_enc_gray;
  assign o_ack          = bus.o_ack;
  assign o_gray         = bus.o_gray;
  assign o_gnt_id       = bus.o_gnt_id;
  assign o_busy         = bus.o_busy;
  assign o_enc_data     = bus.o_enc_data;

  gray_enc_arbiter_core #(
    .REQ_NUM(REQ_NUM),
    .DW     (DW),
    .ENC_LAT(ENC_LAT)
  ) u_core (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus.slave)
  );
endmodule

// File: tb/tb_gray_enc_arbiter.sv
// Bench for gray_enc_arbiter: ENC_LAT=1 and ENC_LAT=3 instances
// against a transaction-level round-robin/encoder model.
module tb_gray_enc_arbiter;
  localparam int N  = 4;
  localparam int DW = 4;
  localparam int LAT [2] = '{1, 3};

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  logic [N-1:0]    reqv  [2];
  logic [N*DW-1:0] datav [2];

  gray_enc_arbiter_if #(.REQ_NUM(N), .DW(DW)) if1 ();
  gray_enc_arbiter_if #(.REQ_NUM(N), .DW(DW)) if3 ();

  assign if1.i_req  = reqv[0];
  assign if1.i_data = datav[0];
  assign if3.i_req  = reqv[1];
  assign if3.i_data = datav[1];

  gray_enc_arbiter #(.REQ_NUM(N), .DW(DW), .ENC_LAT(1)) dut1 (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_req     (if1.i_req),
    .i_data    (if1.i_data),
    .o_ack     (if1.o_ack),
    .o_gray    (if1.o_gray),
    .o_gnt_id  (if1.o_gnt_id),
    .o_busy    (if1.o_busy),
    .o_enc_data(if1.o_enc_data),
    .i_enc_gray(if1.i_enc_gray)
  );

  gray_enc_arbiter #(.REQ_NUM(N), .DW(DW), .ENC_LAT(3)) dut3 (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_req     (if3.i_req),
    .i_data    (if3.i_data),
    .o_ack     (if3.o_ack),
    .o_gray    (if3.o_gray),
    .o_gnt_id  (if3.o_gnt_id),
    .o_busy    (if3.o_busy),
    .o_enc_data(if3.o_enc_data),
    .i_enc_gray(if3.i_enc_gray)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] gray(input logic [DW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // external registered encoders: 1 stage and 3 stages
  logic [DW-1:0] e1, e3a, e3b, e3c;
  always @(posedge clk) begin
    e1  <= gray(if1.o_enc_data);
    e3a <= gray(if3.o_enc_data);
    e3b <= e3a;
    e3c <= e3b;
  end
  assign if1.i_enc_gray = e1;
  assign if3.i_enc_gray = e3c;

  function automatic int rr_next(input int ptr, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[2'((ptr + k) % N)]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  function automatic logic [DW-1:0] lane_of(input logic [N*DW-1:0] v,
                                            input int k);
    return v[k*DW +: DW];
  endfunction

  // transaction model: t counts edges since grant
  logic          m_idle [2];
  int            m_t    [2];
  int            m_ptr  [2];
  int            m_gnt  [2];
  logic [DW-1:0] m_op   [2];
  logic [DW-1:0] m_gray [2];

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_idle[d] <= 1'b1;
        m_t[d]    <= 0;
        m_ptr[d]  <= N - 1;
        m_gnt[d]  <= 0;
        m_op[d]   <= '0;
        m_gray[d] <= '0;
      end else if (m_idle[d]) begin
        if (reqv[d] != '0) begin
          m_ptr[d]  <= rr_next(m_ptr[d], reqv[d]);
          m_gnt[d]  <= rr_next(m_ptr[d], reqv[d]);
          m_op[d]   <= lane_of(datav[d], rr_next(m_ptr[d], reqv[d]));
          m_t[d]    <= 0;
          m_idle[d] <= 1'b0;
        end
      end else begin
        m_t[d] <= m_t[d] + 1;
        if (m_t[d] + 1 == LAT[d] + 1) m_gray[d] <= gray(m_op[d]);
        if (m_t[d] + 1 == LAT[d] + 2) m_idle[d] <= 1'b1;
      end
    end
  end

  function automatic logic [N-1:0] x_ack(input int d);
    if (!m_idle[d] && m_t[d] == LAT[d] + 1) return 4'b0001 << m_gnt[d];
    return '0;
  endfunction

  function automatic logic [N-1:0] d_ack(input int d);
    return (d == 0) ? if1.o_ack : if3.o_ack;
  endfunction
  function automatic logic [DW-1:0] d_gray(input int d);
    return (d == 0) ? if1.o_gray : if3.o_gray;
  endfunction
  function automatic logic [1:0] d_gnt(input int d);
    return (d == 0) ? if1.o_gnt_id : if3.o_gnt_id;
  endfunction
  function automatic logic d_busy(input int d);
    return (d == 0) ? if1.o_busy : if3.o_busy;
  endfunction
  function automatic logic [DW-1:0] d_enc(input int d);
    return (d == 0) ? if1.o_enc_data : if3.o_enc_data;
  endfunction

  task automatic do_reset();
    rst_n    = 1'b0;
    reqv[0]  = '0;
    reqv[1]  = '0;
    datav[0] = '0;
    datav[1] = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int d = 0; d < 2; d++) begin
      checks += 5;
      if (d_ack(d) !== '0) begin
        errors++;
        $display("FAIL reset_ack d%0d got %b want 0", d, d_ack(d));
      end
      if (d_gray(d) !== '0) begin
        errors++;
        $display("FAIL reset_gray d%0d got %b want 0", d, d_gray(d));
      end
      if (d_gnt(d) !== '0) begin
        errors++;
        $display("FAIL reset_gnt d%0d got %0d want 0", d, d_gnt(d));
      end
      if (d_busy(d) !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy d%0d got %b want 0", d, d_busy(d));
      end
      if (d_enc(d) !== '0) begin
        errors++;
        $display("FAIL reset_enc d%0d got %b want 0", d, d_enc(d));
      end
    end
  endtask

  task automatic test_single();
    int busy_n;
    do_reset();
    datav[0] = 16'h0005;
    reqv[0]  = 4'b0001;
    busy_n   = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (if1.o_busy === 1'b1) busy_n++;
      if (i == 0) begin
        checks += 2;
        if (if1.o_enc_data !== 4'b0101) begin
          errors++;
          $display("FAIL single_enc got %b want 0101", if1.o_enc_data);
        end
        if (if1.o_gnt_id !== 2'd0) begin
          errors++;
          $display("FAIL single_gnt got %0d want 0", if1.o_gnt_id);
        end
      end
      checks++;
      if (if1.o_ack !== ((i == 2) ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("FAIL single_ack cyc%0d got %b", i, if1.o_ack);
      end
      if (i == 2) begin
        checks++;
        if (if1.o_gray !== 4'b0111) begin
          errors++;
          $display("FAIL single_gray got %b want 0111", if1.o_gray);
        end
        reqv[0] = '0;
      end
    end
    checks++;
    if (busy_n != 3) begin
      errors++;
      $display("FAIL single_busy_len got %0d want 3", busy_n);
    end
  endtask

  task automatic test_all_four();
    int ids[$];
    logic [DW-1:0] grs[$];
    int cyc[$];
    logic [DW-1:0] wantg [4];
    wantg = '{4'b0000, 4'b0100, 4'b1111, 4'b1000};
    do_reset();
    datav[0] = {4'd15, 4'd10, 4'd7, 4'd0};
    reqv[0]  = 4'b1111;
    for (int i = 0; i < 40 && ids.size() < 4; i++) begin
      @(negedge clk);
      checks += 2;
      if (if1.o_ack !== x_ack(0)) begin
        errors++;
        $display("FAIL four_ack got %b want %b", if1.o_ack, x_ack(0));
      end
      if (if1.o_busy !== !m_idle[0]) begin
        errors++;
        $display("FAIL four_busy got %b want %b", if1.o_busy, !m_idle[0]);
      end
      if (if1.o_ack != '0) begin
        ids.push_back($clog2(if1.o_ack));
        grs.push_back(if1.o_gray);
        cyc.push_back(i);
        reqv[0] = reqv[0] & ~if1.o_ack;
      end
    end
    checks++;
    if (ids.size() != 4) begin
      errors++;
      $display("FAIL four_timeout got %0d acks want 4", ids.size());
    end
    for (int k = 0; k < ids.size(); k++) begin
      checks += 2;
      if (ids[k] != k) begin
        errors++;
        $display("FAIL four_order #%0d got %0d want %0d", k, ids[k], k);
      end
      if (grs[k] !== wantg[k]) begin
        errors++;
        $display("FAIL four_gray #%0d got %b want %b", k, grs[k], wantg[k]);
      end
      if (k > 0) begin
        checks++;
        if (cyc[k] - cyc[k-1] != 4) begin
          errors++;
          $display("FAIL four_spacing #%0d got %0d want 4", k,
                   cyc[k] - cyc[k-1]);
        end
      end
    end
  endtask

  task automatic test_fairness();
    int n;
    int bad;
    do_reset();
    datav[0] = {$urandom}[15:0];
    reqv[0]  = 4'b0101;
    n   = 0;
    bad = 0;
    for (int i = 0; i < 44; i++) begin
      @(negedge clk);
      checks++;
      if (if1.o_ack !== x_ack(0)) begin
        errors++;
        $display("FAIL fair_ack got %b want %b", if1.o_ack, x_ack(0));
      end
      if (if1.o_ack != '0) begin
        checks++;
        if ($clog2(if1.o_ack) != ((n % 2 == 0) ? 0 : 2)) begin
          errors++;
          $display("FAIL fair_order #%0d got %b", n, if1.o_ack);
        end
        if ((if1.o_ack & 4'b1010) != '0) bad++;
        n++;
      end
    end
    checks += 2;
    if (bad != 0) begin
      errors++;
      $display("FAIL fair_starve got %0d acks to 1/3 want 0", bad);
    end
    if (n != 11) begin
      errors++;
      $display("FAIL fair_count got %0d want 11", n);
    end
    reqv[0] = '0;
  endtask

  task automatic test_operand_latch();
    do_reset();
    datav[0] = 16'h0050;
    reqv[0]  = 4'b0010;
    @(negedge clk);
    checks += 2;
    if (if1.o_gnt_id !== 2'd1) begin
      errors++;
      $display("FAIL latch_gnt got %0d want 1", if1.o_gnt_id);
    end
    if (if1.o_enc_data !== 4'd5) begin
      errors++;
      $display("FAIL latch_enc got %0d want 5", if1.o_enc_data);
    end
    datav[0] = 16'h0090;
    @(negedge clk);
    @(negedge clk);
    checks += 2;
    if (if1.o_ack !== 4'b0010) begin
      errors++;
      $display("FAIL latch_ack got %b want 0010", if1.o_ack);
    end
    if (if1.o_gray !== 4'b0111) begin
      errors++;
      $display("FAIL latch_gray got %b want 0111", if1.o_gray);
    end
    reqv[0]  = 4'b1000;
    datav[0] = 16'hC090;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (if1.o_gnt_id !== 2'd3 || if1.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_gnt got %0d/%b want 3/1", if1.o_gnt_id, if1.o_busy);
    end
    reqv[0] = '0;
    @(negedge clk);
    @(negedge clk);
    checks += 2;
    if (if1.o_ack !== 4'b1000) begin
      errors++;
      $display("FAIL drop_ack got %b want 1000", if1.o_ack);
    end
    if (if1.o_gray !== 4'b1010) begin
      errors++;
      $display("FAIL drop_gray got %b want 1010", if1.o_gray);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (if1.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_regrant busy got %b want 0", if1.o_busy);
    end
  endtask

  task automatic test_latency3();
    do_reset();
    datav[1] = 16'h0C00;
    reqv[1]  = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (if3.o_ack !== ((i == 4) ? 4'b0100 : 4'b0000)) begin
        errors++;
        $display("FAIL lat3_ack cyc%0d got %b", i, if3.o_ack);
      end
      if (i == 4) begin
        checks++;
        if (if3.o_gray !== 4'b1010) begin
          errors++;
          $display("FAIL lat3_gray got %b want 1010", if3.o_gray);
        end
      end
      if (i == 5 || i == 6) begin
        checks++;
        if (if3.o_busy !== (i == 6)) begin
          errors++;
          $display("FAIL lat3_regrant cyc%0d busy %b", i, if3.o_busy);
        end
      end
    end
    reqv[1] = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    datav[1] = 16'h0030;
    reqv[1]  = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks += 2;
    if (if3.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_busy got %b want 0", if3.o_busy);
    end
    if (if3.o_enc_data !== '0) begin
      errors++;
      $display("FAIL midrst_enc got %b want 0", if3.o_enc_data);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks += 2;
      if (if3.o_ack !== ((i == 4) ? 4'b0010 : 4'b0000)) begin
        errors++;
        $display("FAIL midrst_ack cyc%0d got %b", i, if3.o_ack);
      end
      if (if3.o_busy !== (i <= 4)) begin
        errors++;
        $display("FAIL midrst_busy cyc%0d got %b", i, if3.o_busy);
      end
      if (i == 4) begin
        checks++;
        if (if3.o_gray !== 4'b0010) begin
          errors++;
          $display("FAIL midrst_gray got %b want 0010", if3.o_gray);
        end
        reqv[1] = '0;
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks += 5;
        if (d_ack(d) !== x_ack(d)) begin
          errors++;
          $display("FAIL rnd_ack d%0d got %b want %b", d, d_ack(d), x_ack(d));
        end
        if (d_gray(d) !== m_gray[d]) begin
          errors++;
          $display("FAIL rnd_gray d%0d got %b want %b", d, d_gray(d),
                   m_gray[d]);
        end
        if (d_gnt(d) !== 2'(m_gnt[d])) begin
          errors++;
          $display("FAIL rnd_gnt d%0d got %0d want %0d", d, d_gnt(d),
                   m_gnt[d]);
        end
        if (d_busy(d) !== !m_idle[d]) begin
          errors++;
          $display("FAIL rnd_busy d%0d got %b want %b", d, d_busy(d),
                   !m_idle[d]);
        end
        if (d_enc(d) !== m_op[d]) begin
          errors++;
          $display("FAIL rnd_enc d%0d got %b want %b", d, d_enc(d), m_op[d]);
        end
        for (int k = 0; k < N; k++) begin
          if (d_ack(d)[k]) begin
            reqv[d][k] = 1'b0;
          end else if (!reqv[d][k] && $urandom_range(0, 3) == 0) begin
            reqv[d][k] = 1'b1;
            datav[d][k*DW +: DW] = 4'($urandom);
          end else if ($urandom_range(0, 7) == 0) begin
            datav[d][k*DW +: DW] = 4'($urandom);
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    errors   = 0;
    checks   = 0;
    rst_n    = 1'b0;
    reqv[0]  = '0;
    reqv[1]  = '0;
    datav[0] = '0;
    datav[1] = '0;
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_operand_latch();
    test_latency3();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gray_enc_arbiter.md
# gray_enc_arbiter

Round-robin scheduler that shares one registered binary-to-Gray encoder among up to REQ_NUM requesters. It latches the winning requester's operand and drives it to the encoder. It then waits the encoder's fixed pipeline latency, captures the Gray result and returns it with a one-hot acknowledge. It sits between client logic and the team's registered Gray encoder, which is instantiated outside this block.

## Interface
- REQ_NUM, 4, number of requesters (2..8)
- DW, 4, operand/result width in bits
- ENC_LAT, 1, encoder latency in clock edges from operand stable to result valid (1..7)
- IDW, clog2(REQ_NUM) (min 1), width of o_gnt_id (derived localparam)

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_req  in  REQ_NUM  level request per requester; held until its o_ack pulse
- i_data  in  REQ_NUM*DW  operand of requester k at [k*DW +: DW]
- o_ack  out  REQ_NUM  one-hot, one-cycle pulse marking o_gray valid for that requester
- o_gray  out  DW  captured Gray result; holds until the next capture
- o_gnt_id  out  IDW  index of current/last granted requester
- o_busy  out  1  high whenever state is not IDLE
- o_enc_data  out  DW  operand to encoder; registered, stable for the whole transaction
- i_enc_gray  in  DW  encoder output

## Operation
- Reset values: state IDLE, o_ack 0, o_gray 0, o_gnt_id 0, o_busy 0, o_enc_data 0, cnt 0, rr pointer REQ_NUM-1 (requester 0 wins first).
- FSM states: IDLE, WAIT, DONE.
- IDLE, when any i_req bit is high at an edge:
  - Pick the first set bit searching upward from pointer+1, wrapping modulo REQ_NUM.
  - Register o_gnt_id, o_enc_data = that lane of i_data, and cnt = ENC_LAT.
  - Update pointer = granted index and go to WAIT.
- IDLE with no request: stay; all outputs hold.
- WAIT, cnt != 0: decrement cnt.
- WAIT, cnt == 0: set o_gray = i_enc_gray and o_ack = onehot(o_gnt_id), then go to DONE.
- DONE: at the next edge clear o_ack and go to IDLE unconditionally. There is no arbitration in DONE, so a requester dropping i_req on seeing o_ack is never regranted.
- Operand is sampled only at the grant edge. Later i_data changes are ignored for the current transaction.
- If i_req of the granted requester drops before completion, the transaction still completes and o_ack still pulses.
- Requests from other requesters arriving during WAIT/DONE are served only after the return to IDLE.
- Reset asserted mid-transaction: every register returns to its reset value immediately. No o_ack is issued for the aborted transaction; the pending request is re-arbitrated after reset release.
- No combinational path from inputs to outputs.

## Timing
- Grant edge G (IDLE samples i_req): o_enc_data, o_gnt_id and o_busy are valid after G.
- Encoder result is valid after edge G+ENC_LAT.
- o_gray and o_ack are updated after edge G+ENC_LAT+1. o_ack stays high for exactly one cycle.
- Return to IDLE after G+ENC_LAT+2. Earliest next grant is at G+ENC_LAT+3.
- Throughput is one transaction per ENC_LAT+3 cycles under continuous load. o_busy is high for ENC_LAT+2 cycles per transaction.
- Fairness: a continuously requesting client waits at most REQ_NUM-1 transactions.

## Test plan
- Reset: after reset, all outputs are 0. Asserting i_rst_n=0 during WAIT drops o_busy to 0 asynchronously, and no o_ack appears afterwards.
- Single request, ENC_LAT=1, with an encoder model computing b^(b>>1). i_req=0001 and lane0=5 gives o_enc_data=0101 after G, and o_ack=0001 with o_gray=0111 after G+2. o_busy is high for 3 cycles.
- All four requesting with lanes 0,7,10,15 held until their ack: grants occur in order 0,1,2,3. o_gray is 0000, 0100, 1111, 1000, with acks spaced 4 cycles apart.
- Fairness: req0 and req2 held high continuously gives a grant sequence 0,2,0,2,… and requesters 1 and 3 are never acked.
- Operand latch: lane1 changes 5→9 one cycle after its grant, and o_gray is 0111 (not 1101). Separately, req3 dropping during WAIT still yields o_ack=1000.
- Latency sweep with ENC_LAT=3 and a 3-stage encoder model: lane2=12 gives o_ack=0100 and o_gray=1010 exactly 4 edges after grant. Re-grant occurs no earlier than G+6.
